// File: rtl/mem_arb_pkg.sv
// Shared definitions for the I/D memory arbiter:
// burst codes, beat counts, FSM states, port ids.
package mem_arb_pkg;

  localparam logic [1:0] SZ_1  = 2'b00;
  localparam logic [1:0] SZ_4  = 2'b01;
  localparam logic [1:0] SZ_8  = 2'b10;
  localparam logic [1:0] SZ_16 = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    I_BURST,
    D_BURST,
    TAIL
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  function automatic logic [4:0] beats_of(
    input logic [1:0] code
  );
    logic [4:0] n;
    n = 5'd1;
    unique case (code)
      SZ_1:    n = 5'd1;
      SZ_4:    n = 5'd4;
      SZ_8:    n = 5'd8;
      SZ_16:   n = 5'd16;
      default: n = 5'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_burst_seq.sv
// Burst sequencer: beat counter, beat address and last-beat flag.
// Ports: clock, reset, load, advance, start, size -> address, last.
module mem_burst_seq
  import mem_arb_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        advance,
  input  logic [31:0] start,
  input  logic [1:0]  size,
  output logic [31:0] address,
  output logic        last
);

  logic [31:0] base_q;
  logic [3:0]  cnt_q;
  logic [3:0]  top_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      base_q <= '0;
      cnt_q  <= '0;
      top_q  <= '0;
    end else if (load) begin
      base_q <= start;
      cnt_q  <= '0;
      top_q  <= 4'(beats_of(size) - 5'd1);
    end else if (advance) begin
      cnt_q  <= cnt_q + 4'd1;
    end
  end

  // Address wraps modulo 2^32.
  assign address = base_q + {26'd0, cnt_q, 2'b00};
  assign last    = (cnt_q == top_q);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one memory between fetch (I) and load/store (D) ports.
// Ports: i_* fetch side, d_* load/store side, m_* memory side, err.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h8002_0000,
  parameter int unsigned MEM_BYTES    = 1048576,
  parameter int unsigned STARVE_LIMIT = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_address,
  input  logic [1:0]  i_access_size,
  output logic        i_grant,
  output logic        i_valid,
  output logic [31:0] i_data,
  input  logic        d_req,
  input  logic        d_rw,
  input  logic [31:0] d_address,
  input  logic [1:0]  d_access_size,
  input  logic [31:0] d_data_in,
  output logic        d_grant,
  output logic        d_valid,
  output logic [31:0] d_data,
  output logic        err,
  output logic [31:0] m_address,
  output logic [31:0] m_data_in,
  output logic [1:0]  m_access_size,
  output logic        m_rw,
  output logic        m_enable,
  input  logic        m_busy,
  input  logic [31:0] m_data_out
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [32:0] END_ADDR =
    33'(BASE_ADDR) + 33'(MEM_BYTES);

  state_t state_q, state_n;

  logic          owner_q;
  logic          rw_q;
  logic          rvalid_q;
  logic [SW-1:0] starve_q;

  logic        arb_en;
  logic        pick_d;
  logic        pick_i;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_rw;
  logic [32:0] req_end;
  logic        bad;
  logic        take;
  logic        load;
  logic        in_burst;
  logic        advance;
  logic [31:0] seq_addr;
  logic        seq_last;
  logic        own_d;
  logic        d_wr;

  // Grants are decided combinationally in IDLE; reset masks them.
  assign arb_en = (state_q == IDLE) & ~reset;

  // D has priority until I has been passed over STARVE_LIMIT times.
  assign pick_d = d_req & (~i_req | (starve_q != STARVE_MAX));
  assign pick_i = i_req & ~pick_d;

  assign req_addr = pick_d ? d_address     : i_address;
  assign req_size = pick_d ? d_access_size : i_access_size;
  assign req_rw   = pick_d ? d_rw          : 1'b1;

  // 33-bit end address so a burst near 2^32 cannot wrap past the check.
  assign req_end = {1'b0, req_addr}
                 + {26'd0, beats_of(req_size), 2'b00};

  assign bad = (req_addr[1:0] != 2'b00)
             | (req_addr < BASE_ADDR)
             | (req_end > END_ADDR);

  assign take = arb_en & (pick_d | pick_i);
  assign load = take & ~bad;

  assign in_burst = (state_q == I_BURST) | (state_q == D_BURST);
  assign advance  = in_burst & ~m_busy;

  assign own_d = (owner_q == PORT_D);
  assign d_wr  = own_d & ~rw_q;

  mem_burst_seq u_seq (
    .clock   (clock),
    .reset   (reset),
    .load    (load),
    .advance (advance),
    .start   (req_addr),
    .size    (req_size),
    .address (seq_addr),
    .last    (seq_last)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= PORT_I;
      rw_q     <= 1'b1;
      rvalid_q <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_n;
      rvalid_q <= advance & rw_q;
      if (load) begin
        owner_q <= pick_d ? PORT_D : PORT_I;
        rw_q    <= req_rw;
      end
      if (take) begin
        if (pick_i) begin
          starve_q <= '0;
        end else if (i_req && starve_q != STARVE_MAX) begin
          starve_q <= starve_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          state_n = pick_d ? D_BURST : I_BURST;
        end
      end
      I_BURST, D_BURST: begin
        if (advance && seq_last) begin
          state_n = rw_q ? TAIL : IDLE;
        end
      end
      TAIL:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    i_grant       = take & pick_i;
    d_grant       = take & pick_d;
    err           = take & bad;
    m_access_size = SZ_1;
    m_enable      = 1'b0;
    m_address     = '0;
    m_rw          = 1'b1;
    m_data_in     = '0;
    i_valid       = 1'b0;
    i_data        = '0;
    d_valid       = 1'b0;
    d_data        = '0;
    if (in_burst) begin
      m_enable  = 1'b1;
      m_address = seq_addr;
      m_rw      = rw_q;
      if (d_wr) begin
        m_data_in = d_data_in;
      end
    end
    // Read data returns one cycle after each accepted beat.
    if (rvalid_q) begin
      if (own_d) begin
        d_valid = 1'b1;
        d_data  = m_data_out;
      end else begin
        i_valid = 1'b1;
        i_data  = m_data_out;
      end
    end
    // Writes are acknowledged in the beat they are accepted.
    if (advance && d_wr) begin
      d_valid = 1'b1;
    end
  end

endmodule
